// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared state encoding, shadow record and match helper
package hazard_stall_unit_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } hsu_state_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } shadow_t;

  // A used, non-x0 source that names a writing producer; x0 never matches
  function automatic logic src_hit(input logic use_src, input logic [REG_W-1:0] rs,
                                   input shadow_t sh);
    return use_src && (rs != '0) && (rs == sh.rd) && sh.regwrite;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_hazard_detect.sv
// rtl/hazard_stall_unit_hazard_detect.sv - required stall count for the ID instruction
module hazard_detect
  import hazard_stall_unit_pkg::*;
(
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_rs1,
  input  logic             i_use_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_use_rs2,
  input  logic             i_is_branch,
  input  shadow_t          i_ex,
  input  shadow_t          i_mem,
  output logic [1:0]       o_need
);

  // Branches read operands in ID, so they need results one stage earlier than EX consumers
  function automatic logic [1:0] src_need(input logic use_src, input logic [REG_W-1:0] rs,
                                          input logic is_br, input shadow_t ex,
                                          input shadow_t mem);
    logic [1:0] n;
    n = 2'd0;
    if (src_hit(use_src, rs, ex)) begin
      if (is_br && ex.memread) n = 2'd2;
      else                     n = 2'd1;
    end else if (is_br && src_hit(use_src, rs, mem) && mem.memread) begin
      n = 2'd1;
    end
    return n;
  endfunction

  logic [1:0] w_n1;
  logic [1:0] w_n2;

  // Worst case over both sources, nothing for an empty ID slot
  always_comb begin
    w_n1   = src_need(i_use_rs1, i_rs1, i_is_branch, i_ex, i_mem);
    w_n2   = src_need(i_use_rs2, i_rs2, i_is_branch, i_ex, i_mem);
    o_need = 2'd0;
    if (i_id_valid) o_need = (w_n1 > w_n2) ? w_n1 : w_n2;
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - RAW stall/bubble/flush/freeze control; HAZARD_PERF_CNT_EN adds stall_cycles
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_is_branch,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             freeze
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  shadow_t    r_ex;
  shadow_t    r_mem;
  hsu_state_e r_state;
  hsu_state_e r_saved_state;
  logic [1:0] r_cnt;
  logic [1:0] r_saved_cnt;

  logic [1:0] w_need;
  logic       w_freeze;
  logic       w_stall;
  logic       w_flush;
  hsu_state_e w_eff_state;
  logic [1:0] w_eff_cnt;
  hsu_state_e w_state_nxt;
  hsu_state_e w_saved_state_nxt;
  logic [1:0] w_cnt_nxt;
  logic [1:0] w_saved_cnt_nxt;
  shadow_t    w_id_rec;

  hazard_detect u_detect (
    .i_id_valid  (id_valid),
    .i_rs1       (id_rs1),
    .i_use_rs1   (id_use_rs1),
    .i_rs2       (id_rs2),
    .i_use_rs2   (id_use_rs2),
    .i_is_branch (id_is_branch),
    .i_ex        (r_ex),
    .i_mem       (r_mem),
    .o_need      (w_need)
  );

  // Next-state and outputs; leaving FREEZE behaves as the saved state in that same cycle
  always_comb begin
    w_freeze          = r_mem.memread & ~mem_ready;
    w_eff_state       = (r_state == ST_FREEZE) ? r_saved_state : r_state;
    w_eff_cnt         = (r_state == ST_FREEZE) ? r_saved_cnt : r_cnt;
    w_stall           = 1'b0;
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_saved_state_nxt = r_saved_state;
    w_saved_cnt_nxt   = r_saved_cnt;
    if (w_freeze) begin
      if (r_state != ST_FREEZE) begin
        w_saved_state_nxt = r_state;
        w_saved_cnt_nxt   = r_cnt;
        w_state_nxt       = ST_FREEZE;
      end
    end else begin
      case (w_eff_state)
        ST_STALL: begin
          w_stall = 1'b1;
          if (w_eff_cnt <= 2'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 2'd0;
          end else begin
            w_state_nxt = ST_STALL;
            w_cnt_nxt   = w_eff_cnt - 2'd1;
          end
        end
        default: begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = ST_RUN;
          if (w_need != 2'd0) begin
            w_stall   = 1'b1;
            w_cnt_nxt = w_need - 2'd1;
            if (w_need > 2'd1) w_state_nxt = ST_STALL;
          end
        end
      endcase
    end
    w_flush = branch_taken & id_is_branch & (w_eff_state == ST_RUN) & (w_need == 2'd0) &
              ~w_freeze;
  end

  assign pc_stall     = w_stall;
  assign if_id_stall  = w_stall;
  assign id_ex_bubble = w_stall;
  assign if_id_flush  = w_flush;
  assign freeze       = w_freeze;

  assign w_id_rec.rd       = id_valid ? id_rd : '0;
  assign w_id_rec.regwrite = id_valid & id_regwrite;
  assign w_id_rec.memread  = id_valid & id_memread;

  // FSM state register with freeze save slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_cnt         <= 2'd0;
      r_saved_state <= ST_RUN;
      r_saved_cnt   <= 2'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_saved_state <= w_saved_state_nxt;
      r_saved_cnt   <= w_saved_cnt_nxt;
    end
  end

  // Shadow EX/MEM destination records track the pipeline, holding while frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else if (!w_freeze) begin
      r_mem <= r_ex;
      r_ex  <= w_stall ? '0 : w_id_rec;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  // Cycles lost to stalls or data-memory freezes, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_stall_cycles <= 32'd0;
    else if (w_stall | w_freeze) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_is_branch;
  logic       branch_taken;
  logic       mem_ready;
  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_bubble;
  logic       if_id_flush;
  logic       freeze;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, freeze}
  localparam logic [4:0] O_IDLE   = 5'b00000;
  localparam logic [4:0] O_STALL  = 5'b11100;
  localparam logic [4:0] O_FLUSH  = 5'b00010;
  localparam logic [4:0] O_FREEZE = 5'b00001;

  logic [4:0] outs;
  assign outs = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, freeze};

  hazard_stall_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_is_branch (id_is_branch),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_bubble (id_ex_bubble),
    .if_id_flush  (if_id_flush),
    .freeze       (freeze)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic br);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_is_branch = br;
  endtask

  task automatic set_nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    set_nop();
    #12;
    chk("reset_outputs", 32'(outs), 32'(O_IDLE));
`ifdef HAZARD_PERF_CNT_EN
    chk("reset_stall_cycles", stall_cycles, 32'd0);
`endif
    tick();
    rst = 1'b0;

    // add x5 -> sub uses x5: one stall
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    sample(); chk("add_x5_no_hazard", 32'(outs), 32'(O_IDLE));
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    sample(); chk("sub_x5_stall", 32'(outs), 32'(O_STALL));
    tick();
    sample(); chk("sub_x5_advance", 32'(outs), 32'(O_IDLE));
    tick(); set_nop(); tick(); tick();

    // x0 producer and consumer never match
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    sample(); chk("x0_no_stall", 32'(outs), 32'(O_IDLE));
    tick(); set_nop(); tick(); tick();

    // add x7 -> beq x7 taken: one stall then flush
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    branch_taken = 1'b1;
    sample(); chk("beq_x7_stall", 32'(outs), 32'(O_STALL));
    tick();
    sample(); chk("beq_x7_flush", 32'(outs), 32'(O_FLUSH));
    tick(); set_nop();
    sample(); chk("beq_x7_after", 32'(outs), 32'(O_IDLE));
    tick(); tick();

    // lw x6 -> beq x6 not taken: two stalls, no flush
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    sample(); chk("lw_beq_nt_stall1", 32'(outs), 32'(O_STALL));
    tick();
    sample(); chk("lw_beq_nt_stall2", 32'(outs), 32'(O_STALL));
    tick();
    sample(); chk("lw_beq_nt_release", 32'(outs), 32'(O_IDLE));
    tick(); set_nop(); tick(); tick();

    // lw x6 -> beq x6 taken: two stalls, then flush
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    branch_taken = 1'b1;
    sample(); chk("lw_beq_t_stall1", 32'(outs), 32'(O_STALL));
    tick();
    sample(); chk("lw_beq_t_stall2", 32'(outs), 32'(O_STALL));
    tick();
    sample(); chk("lw_beq_t_flush", 32'(outs), 32'(O_FLUSH));
    tick(); set_nop(); tick(); tick();

    // lw x6 -> beq x6, memory not ready for 3 cycles during STALL
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    sample(); chk("frz_first_stall", 32'(outs), 32'(O_STALL));
`ifdef HAZARD_PERF_CNT_EN
    chk("frz_cycles_before", stall_cycles, 32'd6);
`endif
    tick();
    mem_ready = 1'b0;
    sample(); chk("frz_cycle1", 32'(outs), 32'(O_FREEZE));
    tick();
    sample(); chk("frz_cycle2", 32'(outs), 32'(O_FREEZE));
    tick();
    sample(); chk("frz_cycle3", 32'(outs), 32'(O_FREEZE));
    tick();
    mem_ready = 1'b1;
    sample(); chk("frz_remaining_stall", 32'(outs), 32'(O_STALL));
    tick();
    sample(); chk("frz_release", 32'(outs), 32'(O_IDLE));
`ifdef HAZARD_PERF_CNT_EN
    chk("frz_cycles_after", stall_cycles, 32'd11);
`endif
    tick(); set_nop(); tick(); tick();

    // reset asserted while in STALL
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    sample(); chk("rst_pre_stall1", 32'(outs), 32'(O_STALL));
    tick();
    sample(); chk("rst_pre_stall2", 32'(outs), 32'(O_STALL));
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(outs), 32'(O_IDLE));
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_mid_stall_cycles", stall_cycles, 32'd0);
`endif
    tick();
    rst = 1'b0;
    sample(); chk("rst_release_run", 32'(outs), 32'(O_IDLE));
    tick();
    sample(); chk("rst_release_run2", 32'(outs), 32'(O_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Producer-side companion to the forwarding logic in the 5-stage pipeline: detects RAW hazards that forwarding cannot cover (no EX/MEM→EX path, branch operands in ID only fed from EX/MEM) and stalls, bubbles, flushes or freezes the pipeline. It keeps its own shadow copies of the EX and MEM destination info, so hazard decisions do not depend on the pipeline registers. A small FSM sequences multi-cycle stalls and data-memory freezes.

## Interface
- No parameters; register index width fixed at 5.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5  ID source registers
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_rd  in  5  ID destination
- id_regwrite, id_memread  in  1  ID writes rd / is a load
- id_is_branch  in  1  ID instruction resolves in ID (branch, jalr)
- branch_taken  in  1  ID redirect, valid only when not stalled
- mem_ready  in  1  data memory completes this cycle
- pc_stall, if_id_stall  out  1  hold PC and IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- if_id_flush  out  1  squash IF/ID
- freeze  out  1  hold every pipeline register
- stall_cycles  out  32  only with HAZARD_PERF_CNT_EN

## Operation
- Shadows: ex_{rd,regwrite,memread}, mem_{rd,regwrite,memread}. On advance (freeze=0): mem_* ← ex_*; ex_* ← id_* gated by id_valid, or zeros if id_ex_bubble. Freeze: hold. rd=0 never matches.
- Required stall count N for the ID instruction (max over used sources):
  - non-branch, src = ex_rd with ex_regwrite: N=1.
  - non-branch, src = mem_rd: N=0 (MEM/WB→EX forward covers).
  - branch, src = ex_rd, ex_memread=0: N=1; ex_memread=1: N=2.
  - branch, src = mem_rd with mem_memread=1: N=1; mem_memread=0: N=0.
- States RUN, STALL, FREEZE; 2-bit stall_cnt.
  - RUN: N>0 → STALL with stall_cnt=N−1; this cycle pc_stall=if_id_stall=id_ex_bubble=1.
  - STALL: stall outputs asserted; stall_cnt=0 → RUN, else decrement. Re-evaluated N on exit must be 0 (verify assertion).
  - Any state, mem_ready=0 with mem_memread (load/store in MEM) → FREEZE; state/stall_cnt saved; freeze=1, all other outputs 0. mem_ready=1 → return to saved state next cycle.
- if_id_flush = branch_taken & id_is_branch & state RUN & N=0 & !freeze.
- Precedence: freeze > stall > flush.

## Timing
- Reset: all outputs 0, state RUN, stall_cnt 0, shadows zero, stall_cycles 0.
- Outputs combinational from state, shadows and ID inputs; same-cycle effect.
- Shadows, state, counter update on rising clk only.
- Reset mid-stall or mid-freeze: immediate return to reset values.
- mem_ready low entering during STALL: count is preserved, not consumed.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cycles increments by 1 each cycle pc_stall=1 or freeze=1, wraps modulo 2^32.
- Undefined: port and counter absent.

## Structure
- Shared package: state encoding (RUN=2'd0, STALL=2'd1, FREEZE=2'd2) and the shadow-record typedef (rd, regwrite, memread).
- One sub-module: hazard_detect (combinational N computation from ID fields and shadows); FSM and shadows stay in the top.

## Test plan
- add x5 in EX, sub using x5 in ID → one cycle pc_stall=id_ex_bubble=1, then advance; no stall next cycle.
- lw x6 in EX, beq x6,x0 in ID → exactly 2 stall cycles, then flush only if branch_taken=1.
- add x7 in EX, beq x7 in ID, branch_taken=1 → 1 stall, then if_id_flush=1 for one cycle.
- Consumer reads x0 with producer rd=0 in EX → no stall.
- lw in MEM with mem_ready low 3 cycles during STALL (stall_cnt=1) → freeze 3 cycles, then remaining stall cycle, stall_cycles +4 with macro.
- rst asserted mid-STALL → all outputs 0 in the same cycle, RUN after release.
